// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control for the
// execute stage. Detects load-use hazards, inserts bubbles on stall or flush,
// bypasses same-cycle writeback data into the captured operands, and keeps
// saturating stall/flush event counters.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ID_VALID,
    input  logic [XLEN-1:0]       ID_PC,
    input  logic [XLEN-1:0]       ID_RS1_DATA,
    input  logic [XLEN-1:0]       ID_RS2_DATA,
    input  logic [XLEN-1:0]       ID_IMM,
    input  logic [REG_ADDR_W-1:0] ID_ARS1,
    input  logic [REG_ADDR_W-1:0] ID_ARS2,
    input  logic [REG_ADDR_W-1:0] ID_ARD,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic                  ID_REGWRITE,
    input  logic                  ID_MEMREAD,
    input  logic                  ID_MEMWRITE,
    input  logic                  ID_MEMTOREG,
    input  logic                  ID_ALUSRC,
    input  logic [3:0]            ID_ALUOP,
    input  logic                  WB_REGWRITE,
    input  logic [REG_ADDR_W-1:0] WB_ARD,
    input  logic [XLEN-1:0]       WB_DATA,
    input  logic                  FLUSH,
    output logic                  STALL,
    output logic                  EX_VALID,
    output logic [XLEN-1:0]       EX_PC,
    output logic [XLEN-1:0]       EX_RS1_DATA,
    output logic [XLEN-1:0]       EX_RS2_DATA,
    output logic [XLEN-1:0]       EX_IMM,
    output logic [REG_ADDR_W-1:0] EX_ARS1,
    output logic [REG_ADDR_W-1:0] EX_ARS2,
    output logic [REG_ADDR_W-1:0] EX_ARD,
    output logic                  EX_REGWRITE,
    output logic                  EX_MEMREAD,
    output logic                  EX_MEMWRITE,
    output logic                  EX_MEMTOREG,
    output logic                  EX_ALUSRC,
    output logic [3:0]            EX_ALUOP,
    output logic [CNT_W-1:0]      STALL_COUNT,
    output logic [CNT_W-1:0]      FLUSH_COUNT
);

    logic            rs1_hit, rs2_hit;
    logic            rs1_byp, rs2_byp;
    logic            bubble;
    logic [XLEN-1:0] rs1_cap, rs2_cap;

    // Load in EX whose destination is read by the instruction in ID. A store
    // reading the load result through rs2 also stalls; conservative but simple.
    assign rs1_hit = ID_USES_RS1 && (ID_ARS1 == EX_ARD);
    assign rs2_hit = ID_USES_RS2 && (ID_ARS2 == EX_ARD);
    // A flush squashes the ID instruction anyway, so it masks the stall.
    assign STALL   = ID_VALID && EX_VALID && EX_MEMREAD && (EX_ARD != '0)
                     && (rs1_hit || rs2_hit) && !FLUSH;
    assign bubble  = FLUSH || STALL;

    // Writeback in the same cycle as decode: the register file read missed it,
    // so take WB_DATA directly. x0 is never bypassed.
    assign rs1_byp = WB_REGWRITE && (WB_ARD != '0) && (WB_ARD == ID_ARS1);
    assign rs2_byp = WB_REGWRITE && (WB_ARD != '0) && (WB_ARD == ID_ARS2);
    assign rs1_cap = rs1_byp ? WB_DATA : ID_RS1_DATA;
    assign rs2_cap = rs2_byp ? WB_DATA : ID_RS2_DATA;

    // Stage register: reset and bubble both load all-zero (zeroed addresses keep
    // the forwarding unit from matching); otherwise capture decode.
    always_ff @(posedge CLK) begin
        if (RST || bubble) begin
            EX_VALID    <= 1'b0;
            EX_PC       <= '0;
            EX_RS1_DATA <= '0;
            EX_RS2_DATA <= '0;
            EX_IMM      <= '0;
            EX_ARS1     <= '0;
            EX_ARS2     <= '0;
            EX_ARD      <= '0;
            EX_REGWRITE <= 1'b0;
            EX_MEMREAD  <= 1'b0;
            EX_MEMWRITE <= 1'b0;
            EX_MEMTOREG <= 1'b0;
            EX_ALUSRC   <= 1'b0;
            EX_ALUOP    <= '0;
        end else begin
            EX_VALID    <= ID_VALID;
            EX_PC       <= ID_PC;
            EX_RS1_DATA <= rs1_cap;
            EX_RS2_DATA <= rs2_cap;
            EX_IMM      <= ID_IMM;
            EX_ARS1     <= ID_ARS1;
            EX_ARS2     <= ID_ARS2;
            EX_ARD      <= ID_ARD;
            // Control of an empty slot must never cause side effects downstream.
            EX_REGWRITE <= ID_REGWRITE && ID_VALID;
            EX_MEMREAD  <= ID_MEMREAD  && ID_VALID;
            EX_MEMWRITE <= ID_MEMWRITE && ID_VALID;
            EX_MEMTOREG <= ID_MEMTOREG && ID_VALID;
            EX_ALUSRC   <= ID_ALUSRC   && ID_VALID;
            EX_ALUOP    <= ID_VALID ? ID_ALUOP : 4'd0;
        end
    end

    // Saturating event counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            STALL_COUNT <= '0;
            FLUSH_COUNT <= '0;
        end else begin
            if (STALL && (STALL_COUNT != '1))
                STALL_COUNT <= STALL_COUNT + CNT_W'(1);
            if (FLUSH && (FLUSH_COUNT != '1))
                FLUSH_COUNT <= FLUSH_COUNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a reference model predicts each captured EX
// record, expectations are queued when stimulus is driven and popped after the
// clock edge. A second instance with 4-bit counters covers saturation.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [RW-1:0]   ars1;
        logic [RW-1:0]   ars2;
        logic [RW-1:0]   ard;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            alusrc;
        logic [3:0]      aluop;
    } ex_t;

    logic            CLK = 1'b0;
    logic            RST, FLUSH;
    logic            ID_VALID, ID_USES_RS1, ID_USES_RS2;
    logic [XLEN-1:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM, WB_DATA;
    logic [RW-1:0]   ID_ARS1, ID_ARS2, ID_ARD, WB_ARD;
    logic            ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE, ID_MEMTOREG, ID_ALUSRC;
    logic [3:0]      ID_ALUOP;
    logic            WB_REGWRITE;

    logic            STALL, EX_VALID;
    logic [XLEN-1:0] EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM;
    logic [RW-1:0]   EX_ARS1, EX_ARS2, EX_ARD;
    logic            EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, EX_MEMTOREG, EX_ALUSRC;
    logic [3:0]      EX_ALUOP;
    logic [15:0]     STALL_COUNT, FLUSH_COUNT;

    logic            s4_stall, s4_valid;
    logic [XLEN-1:0] s4_pc, s4_rs1, s4_rs2, s4_imm;
    logic [RW-1:0]   s4_ars1, s4_ars2, s4_ard;
    logic            s4_rw, s4_mr, s4_mw, s4_mtr, s4_as;
    logic [3:0]      s4_aluop;
    logic [3:0]      s4_stall_count, s4_flush_count;

    always #5 CLK = ~CLK;

    id_ex_stage dut (
        .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
        .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
        .ID_ARS1(ID_ARS1), .ID_ARS2(ID_ARS2), .ID_ARD(ID_ARD),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .ID_REGWRITE(ID_REGWRITE), .ID_MEMREAD(ID_MEMREAD), .ID_MEMWRITE(ID_MEMWRITE),
        .ID_MEMTOREG(ID_MEMTOREG), .ID_ALUSRC(ID_ALUSRC), .ID_ALUOP(ID_ALUOP),
        .WB_REGWRITE(WB_REGWRITE), .WB_ARD(WB_ARD), .WB_DATA(WB_DATA), .FLUSH(FLUSH),
        .STALL(STALL), .EX_VALID(EX_VALID), .EX_PC(EX_PC),
        .EX_RS1_DATA(EX_RS1_DATA), .EX_RS2_DATA(EX_RS2_DATA), .EX_IMM(EX_IMM),
        .EX_ARS1(EX_ARS1), .EX_ARS2(EX_ARS2), .EX_ARD(EX_ARD),
        .EX_REGWRITE(EX_REGWRITE), .EX_MEMREAD(EX_MEMREAD), .EX_MEMWRITE(EX_MEMWRITE),
        .EX_MEMTOREG(EX_MEMTOREG), .EX_ALUSRC(EX_ALUSRC), .EX_ALUOP(EX_ALUOP),
        .STALL_COUNT(STALL_COUNT), .FLUSH_COUNT(FLUSH_COUNT)
    );

    id_ex_stage #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
        .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
        .ID_ARS1(ID_ARS1), .ID_ARS2(ID_ARS2), .ID_ARD(ID_ARD),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .ID_REGWRITE(ID_REGWRITE), .ID_MEMREAD(ID_MEMREAD), .ID_MEMWRITE(ID_MEMWRITE),
        .ID_MEMTOREG(ID_MEMTOREG), .ID_ALUSRC(ID_ALUSRC), .ID_ALUOP(ID_ALUOP),
        .WB_REGWRITE(WB_REGWRITE), .WB_ARD(WB_ARD), .WB_DATA(WB_DATA), .FLUSH(FLUSH),
        .STALL(s4_stall), .EX_VALID(s4_valid), .EX_PC(s4_pc),
        .EX_RS1_DATA(s4_rs1), .EX_RS2_DATA(s4_rs2), .EX_IMM(s4_imm),
        .EX_ARS1(s4_ars1), .EX_ARS2(s4_ars2), .EX_ARD(s4_ard),
        .EX_REGWRITE(s4_rw), .EX_MEMREAD(s4_mr), .EX_MEMWRITE(s4_mw),
        .EX_MEMTOREG(s4_mtr), .EX_ALUSRC(s4_as), .EX_ALUOP(s4_aluop),
        .STALL_COUNT(s4_stall_count), .FLUSH_COUNT(s4_flush_count)
    );

    ex_t dut_ex;
    always_comb begin
        dut_ex          = '0;
        dut_ex.valid    = EX_VALID;
        dut_ex.pc       = EX_PC;
        dut_ex.rs1      = EX_RS1_DATA;
        dut_ex.rs2      = EX_RS2_DATA;
        dut_ex.imm      = EX_IMM;
        dut_ex.ars1     = EX_ARS1;
        dut_ex.ars2     = EX_ARS2;
        dut_ex.ard      = EX_ARD;
        dut_ex.regwrite = EX_REGWRITE;
        dut_ex.memread  = EX_MEMREAD;
        dut_ex.memwrite = EX_MEMWRITE;
        dut_ex.memtoreg = EX_MEMTOREG;
        dut_ex.alusrc   = EX_ALUSRC;
        dut_ex.aluop    = EX_ALUOP;
    end

    int          n_vec = 0;
    int          n_err = 0;
    ex_t         m_ex  = '0;
    ex_t         sb[$];
    logic [15:0] exp_sc = '0, exp_fc = '0;
    logic [3:0]  exp_sc4 = '0, exp_fc4 = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] d1,
                          input logic [XLEN-1:0] d2, input logic [RW-1:0] a1, input logic [RW-1:0] a2,
                          input logic [RW-1:0] ad, input logic u1, input logic u2,
                          input logic rw, input logic mr, input logic mw, input logic [3:0] op);
        ID_VALID = v;  ID_PC = pc; ID_RS1_DATA = d1; ID_RS2_DATA = d2;
        ID_IMM = pc ^ 32'h0000_0F0F;
        ID_ARS1 = a1; ID_ARS2 = a2; ID_ARD = ad; ID_USES_RS1 = u1; ID_USES_RS2 = u2;
        ID_REGWRITE = rw; ID_MEMREAD = mr; ID_MEMWRITE = mw; ID_MEMTOREG = mr;
        ID_ALUSRC = mr | mw; ID_ALUOP = op;
    endtask

    function automatic logic model_stall(input logic flush_i);
        logic hit;
        hit = (ID_USES_RS1 && ID_ARS1 == m_ex.ard) || (ID_USES_RS2 && ID_ARS2 == m_ex.ard);
        return ID_VALID && m_ex.valid && m_ex.memread && (m_ex.ard != 0) && hit && !flush_i;
    endfunction

    function automatic ex_t model_next(input logic rst_i, input logic flush_i, input logic stall_i);
        ex_t n;
        n = '0;
        if (rst_i || flush_i || stall_i) return n;
        n.valid    = ID_VALID;
        n.pc       = ID_PC;
        n.rs1      = (WB_REGWRITE && WB_ARD != 0 && WB_ARD == ID_ARS1) ? WB_DATA : ID_RS1_DATA;
        n.rs2      = (WB_REGWRITE && WB_ARD != 0 && WB_ARD == ID_ARS2) ? WB_DATA : ID_RS2_DATA;
        n.imm      = ID_IMM;
        n.ars1     = ID_ARS1;
        n.ars2     = ID_ARS2;
        n.ard      = ID_ARD;
        n.regwrite = ID_REGWRITE & ID_VALID;
        n.memread  = ID_MEMREAD  & ID_VALID;
        n.memwrite = ID_MEMWRITE & ID_VALID;
        n.memtoreg = ID_MEMTOREG & ID_VALID;
        n.alusrc   = ID_ALUSRC   & ID_VALID;
        n.aluop    = ID_VALID ? ID_ALUOP : 4'd0;
        return n;
    endfunction

    // One clock: check combinational STALL, queue the predicted EX record,
    // clock, then pop and compare the stage and both counter sets.
    task automatic step(input string tag, input logic rst_i, input logic flush_i);
        logic es;
        ex_t  got, want;
        RST = rst_i; FLUSH = flush_i;
        #1;
        es = model_stall(flush_i);
        chk({tag, ".stall"}, 256'(STALL), 256'(es));
        sb.push_back(model_next(rst_i, flush_i, es));
        if (rst_i) begin
            exp_sc = '0; exp_fc = '0; exp_sc4 = '0; exp_fc4 = '0;
        end else begin
            if (es && exp_sc != '1) exp_sc++;
            if (flush_i && exp_fc != '1) exp_fc++;
            if (es && exp_sc4 != '1) exp_sc4++;
            if (flush_i && exp_fc4 != '1) exp_fc4++;
        end
        @(posedge CLK);
        #1;
        got  = dut_ex;
        want = sb.pop_front();
        m_ex = want;
        chk({tag, ".ex"}, 256'(got), 256'(want));
        chk({tag, ".stall_cnt"}, 256'(STALL_COUNT), 256'(exp_sc));
        chk({tag, ".flush_cnt"}, 256'(FLUSH_COUNT), 256'(exp_fc));
        chk({tag, ".stall_cnt4"}, 256'(s4_stall_count), 256'(exp_sc4));
        chk({tag, ".flush_cnt4"}, 256'(s4_flush_count), 256'(exp_fc4));
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0;
        WB_REGWRITE = 1'b0; WB_ARD = '0; WB_DATA = '0;

        // Reset held two cycles with a live, random decode slot.
        set_id(1, $urandom, $urandom, $urandom, 5'(($urandom % 31) + 1), 5'($urandom),
               5'($urandom), 1, 1, 1, 0, 1, 4'($urandom));
        step("rst0", 1, 0);
        step("rst1", 1, 0);
        chk("rst.ex_valid", 256'(EX_VALID), 256'(0));
        chk("rst.ex_pc", 256'(EX_PC), 256'(0));
        // First edge after release captures the decode slot unchanged.
        step("rst_rel", 0, 0);
        chk("rst_rel.pc", 256'(EX_PC), 256'(ID_PC));
        chk("rst_rel.rs1", 256'(EX_RS1_DATA), 256'(ID_RS1_DATA));

        // Load-use: lw x5 then add x6,x5,x7 -> one stall, bubble, then add enters.
        set_id(1, 32'h100, 32'h1000, 0, 2, 0, 5, 1, 0, 1, 1, 0, 4'd0);
        step("lw_x5", 0, 0);
        set_id(1, 32'h104, 32'h0A, 32'h0B, 5, 7, 6, 1, 1, 1, 0, 0, 4'd2);
        step("lu_stall", 0, 0);
        chk("lu.stall_count", 256'(STALL_COUNT), 256'(1));
        chk("lu.bubble_valid", 256'(EX_VALID), 256'(0));
        chk("lu.bubble_ard", 256'(EX_ARD), 256'(0));
        #1;
        chk("lu.stall_drops", 256'(STALL), 256'(0));
        step("lu_add", 0, 0);
        chk("lu.add_pc", 256'(EX_PC), 256'(32'h104));

        // No false stall: lw x0 then a reader of x0.
        set_id(1, 32'h200, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 4'd0);
        step("lw_x0", 0, 0);
        set_id(1, 32'h204, 1, 2, 0, 0, 8, 1, 1, 1, 0, 0, 4'd1);
        step("x0_use", 0, 0);
        // lw x5 then ARS2=5 without USES_RS2.
        set_id(1, 32'h208, 0, 0, 1, 0, 5, 1, 0, 1, 1, 0, 4'd0);
        step("lw_x5b", 0, 0);
        set_id(1, 32'h20C, 3, 4, 1, 5, 9, 1, 0, 1, 0, 0, 4'd3);
        step("no_rs2_use", 0, 0);
        // ALU op writing x5 then a reader of x5.
        set_id(1, 32'h210, 3, 4, 1, 2, 5, 1, 1, 1, 0, 0, 4'd4);
        step("alu_x5", 0, 0);
        set_id(1, 32'h214, 5, 6, 5, 5, 10, 1, 1, 1, 0, 0, 4'd5);
        step("alu_use", 0, 0);
        // Store consuming a load via rs2 stalls conservatively.
        set_id(1, 32'h218, 0, 0, 1, 0, 12, 1, 0, 1, 1, 0, 4'd0);
        step("lw_x12", 0, 0);
        set_id(1, 32'h21C, 7, 8, 2, 12, 0, 1, 1, 0, 0, 1, 4'd0);
        step("sw_stall", 0, 0);
        chk("sw.stall_count", 256'(STALL_COUNT), 256'(2));
        step("sw_go", 0, 0);

        // Flush with a simultaneous load-use match.
        set_id(1, 32'h300, 0, 0, 1, 0, 5, 1, 0, 1, 1, 0, 4'd0);
        step("lw_x5c", 0, 0);
        set_id(1, 32'h304, 1, 2, 5, 0, 6, 1, 0, 1, 0, 0, 4'd2);
        step("flush_lu", 0, 1);
        chk("flush.count", 256'(FLUSH_COUNT), 256'(1));
        chk("flush.stall_cnt_same", 256'(STALL_COUNT), 256'(2));
        chk("flush.bubble_valid", 256'(EX_VALID), 256'(0));

        // WB bypass into both operands, then x0 which must not bypass.
        WB_REGWRITE = 1; WB_ARD = 3; WB_DATA = 32'hDEADBEEF;
        set_id(1, 32'h400, 32'h11, 32'h11, 3, 3, 9, 1, 1, 1, 0, 0, 4'd6);
        step("byp", 0, 0);
        chk("byp.rs1", 256'(EX_RS1_DATA), 256'(32'hDEADBEEF));
        chk("byp.rs2", 256'(EX_RS2_DATA), 256'(32'hDEADBEEF));
        WB_ARD = 0;
        set_id(1, 32'h404, 32'h11, 32'h11, 0, 0, 9, 1, 1, 1, 0, 0, 4'd6);
        step("byp_x0", 0, 0);
        chk("byp_x0.rs1", 256'(EX_RS1_DATA), 256'(32'h11));
        chk("byp_x0.rs2", 256'(EX_RS2_DATA), 256'(32'h11));
        // Independent per-operand bypass, USES_* ignored.
        WB_ARD = 3;
        set_id(1, 32'h408, 32'h22, 32'h33, 3, 4, 9, 0, 0, 1, 0, 0, 4'd6);
        step("byp_rs1only", 0, 0);
        chk("byp1.rs1", 256'(EX_RS1_DATA), 256'(32'hDEADBEEF));
        chk("byp1.rs2", 256'(EX_RS2_DATA), 256'(32'h33));
        WB_REGWRITE = 0;

        // Invalid slot loads data but zeroed control.
        set_id(0, 32'h500, 32'h55, 32'h66, 1, 2, 3, 1, 1, 1, 1, 1, 4'd9);
        step("invalid", 0, 0);
        chk("invalid.regwrite", 256'(EX_REGWRITE), 256'(0));
        chk("invalid.pc", 256'(EX_PC), 256'(32'h500));

        // Reset during a stall: stage comes out holding a bubble.
        set_id(1, 32'h600, 0, 0, 1, 0, 5, 1, 0, 1, 1, 0, 4'd0);
        step("lw_x5d", 0, 0);
        set_id(1, 32'h604, 1, 2, 5, 0, 6, 1, 0, 1, 0, 0, 4'd2);
        step("rst_stall", 1, 0);
        chk("rst_stall.valid", 256'(EX_VALID), 256'(0));
        step("post_rst", 0, 0);

        // Saturation on the 4-bit counter instance.
        for (int i = 0; i < 20; i++) step("sat", 0, 1);
        chk("sat.flush4", 256'(s4_flush_count), 256'(4'hF));
        chk("sat.flush16", 256'(FLUSH_COUNT), 256'(20));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage core: captures decoded operands and control from decode, presents them to execute.
- Its EX_ARS1/EX_ARS2/EX_ARD/EX_REGWRITE outputs feed the forwarding unit.
- Owns load-use hazard detection (STALL to PC and IF/ID), bubble insertion, branch flush, and the WB-to-ID register bypass.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register address width
CNT_W, 16, width of STALL_COUNT / FLUSH_COUNT

Ports:
CLK  in  1  core clock, all state on rising edge
RST  in  1  synchronous, active-high reset
ID_VALID  in  1  decode slot holds a real instruction
ID_PC  in  XLEN  instruction PC
ID_RS1_DATA, ID_RS2_DATA  in  XLEN  register file read data
ID_IMM  in  XLEN  sign-extended immediate
ID_ARS1, ID_ARS2, ID_ARD  in  REG_ADDR_W  source/destination addresses
ID_USES_RS1, ID_USES_RS2  in  1  instruction actually reads rs1/rs2
ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE, ID_MEMTOREG, ID_ALUSRC  in  1  control
ID_ALUOP  in  4  ALU operation
WB_REGWRITE  in  1  writeback enable
WB_ARD  in  REG_ADDR_W  writeback address
WB_DATA  in  XLEN  writeback data
FLUSH  in  1  taken branch/jump resolved in EX; squash ID
STALL  out  1  combinational; hold PC and IF/ID this cycle
EX_VALID, EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM, EX_ARS1, EX_ARS2, EX_ARD, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, EX_MEMTOREG, EX_ALUSRC, EX_ALUOP  out  same widths as ID_*  registered stage outputs
STALL_COUNT, FLUSH_COUNT  out  CNT_W  event counters

Behaviour:
- Reset (RST=1 at edge): every EX_* register and both counters load 0. STALL is combinational and follows its equation during reset.
  - RST wins over FLUSH and STALL.
  - Reset mid-stall: the stage comes out holding a bubble.
- Hazard equation:
  - STALL = ID_VALID & EX_VALID & EX_MEMREAD & (EX_ARD != 0) & ((ID_USES_RS1 & ID_ARS1==EX_ARD) | (ID_USES_RS2 & ID_ARS2==EX_ARD)) & !FLUSH.
  - A load feeding a store's rs2 also stalls (conservative).
- Per-edge update, priority RST > FLUSH > STALL > load:
  - FLUSH=1: load bubble.
  - STALL=1: load bubble. Upstream holds, so the same ID instruction is presented again next cycle.
  - Otherwise: EX_* <= ID_* (EX_VALID <= ID_VALID).
- Bubble definition:
  - EX_VALID=0; all control bits 0; EX_ALUOP=0.
  - EX_ARD=EX_ARS1=EX_ARS2=0, so the forwarding unit never matches.
  - Data fields and EX_PC = 0.
- ID_VALID=0 with no stall/flush: load normally. Control bits are additionally forced to 0 when ID_VALID=0.
- Stall length: exactly 1 cycle per load-use. The following cycle EX holds a bubble, so STALL drops.
- WB bypass, applied on capture only:
  - If WB_REGWRITE & WB_ARD!=0 & WB_ARD==ID_ARS1, EX_RS1_DATA <= WB_DATA instead of ID_RS1_DATA. Same for rs2 independently.
  - Never applies for x0. ID_USES_* is ignored for the bypass.
- Counters:
  - STALL_COUNT increments on each edge where STALL=1 and RST=0.
  - FLUSH_COUNT increments on each edge where FLUSH=1 and RST=0.
  - Both saturate at all-ones; no wrap.
- FLUSH and hazard together: STALL output is 0, only FLUSH_COUNT increments, bubble loaded.
- No X propagation: every EX_* register is assigned on every edge.

Test Plan:
- Reset: hold RST 2 cycles with ID_VALID=1 and random ID_* -> all EX_* = 0, counters = 0. After release, the next edge loads ID_* unchanged.
- Load-use: EX holds lw x5 (MEMREAD=1, ARD=5); ID presents add x6,x5,x7 (USES_RS1=1, ARS1=5) -> STALL=1 for one cycle. Bubble in EX (VALID=0, ARD=0). Add enters EX next edge. STALL_COUNT=1.
- No false stall:
  - lw x0 followed by a consumer of x0 -> STALL=0.
  - lw x5 followed by an instruction with ARS2=5 but USES_RS2=0 -> STALL=0.
  - ALU op writing x5 followed by a consumer of x5 -> STALL=0.
- Flush priority: FLUSH=1 in the same cycle as a load-use match -> STALL=0, bubble loaded, FLUSH_COUNT=1, STALL_COUNT unchanged.
- WB bypass:
  - WB_REGWRITE=1, WB_ARD=3, WB_DATA=0xDEADBEEF, ID_ARS1=ID_ARS2=3, ID_RS*_DATA=0x11 -> EX_RS1_DATA = EX_RS2_DATA = 0xDEADBEEF.
  - Same with WB_ARD=0 -> both 0x11.
- Saturation: CNT_W=4 override, 20 consecutive flushes -> FLUSH_COUNT stays 0xF.
